// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned BYTE_CNT_W = 2;

  // Word index needs one extra bit so a full-depth count still fits.
  function automatic int unsigned idx_width(input int unsigned mem_size);
    return $clog2(mem_size) + 1;
  endfunction

endpackage

// File: rtl/rx_word_assembler.sv
// Collects four handshaken bytes LSB-first; word_valid pulses on the 4th byte
// with word already including that byte.
module rx_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [23:0]           shreg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (byte_fire) begin
      byte_cnt <= byte_cnt + 1'b1;
      shreg    <= {byte_data, shreg[23:8]};
    end
  end

  // The current byte is merged combinationally so the caller can act on the
  // complete word in the same cycle as the last handshake.
  always_comb begin
    word       = {byte_data, shreg};
    word_valid = byte_fire && (byte_cnt == '1);
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> instruction memory writes.
// Optional trailing checksum field enabled by IMEM_LOADER_CHKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core,
  input  logic        Load_Start,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Valid,
  output logic        Rx_Ready,
  output logic        Imem_We,
  output logic [31:0] Imem_Addr,
  output logic [31:0] Imem_Wdata,
  output logic        Core_Hold,
  output logic        Load_Done,
  output logic        Load_Error
);

  localparam int unsigned IDX_W = idx_width(MEM_SIZE);

  state_t            state, state_nxt;
  logic [31:0]       len_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              byte_fire;
  logic              start_ok;
  logic              last_word;
  logic [31:0]       word;
  logic              word_valid;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [31:0]       sum_q;
`endif

  assign byte_fire  = Rx_Valid && Rx_Ready;
  assign start_ok   = Load_Start && (state == IDLE || state == DONE || state == ERROR);
  assign last_word  = (32'(idx_q) + 32'd1) == len_q;
  assign Imem_Addr  = addr_q;
  assign Imem_Wdata = wdata_q;

  rx_word_assembler u_asm (
    .clk        (Clk_Core),
    .rst        (Rst_Core),
    .clear      (start_ok),
    .byte_fire  (byte_fire),
    .byte_data  (Rx_Data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state   <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_q <= '0;
        idx_q <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
        sum_q <= '0;
`endif
      end
      if (state == LEN && word_valid) len_q <= word;
      // Address and data are captured on the last byte so they are stable during WRITE.
      if (state == DATA && word_valid) begin
        wdata_q <= word;
        addr_q  <= BASE_ADDR + (32'(idx_q) << 2);
      end
      if (state == WRITE) begin
        idx_q <= idx_q + 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
        sum_q <= sum_q + wdata_q;
`endif
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    Rx_Ready   = 1'b0;
    Imem_We    = 1'b0;
    Core_Hold  = 1'b0;
    Load_Done  = 1'b0;
    Load_Error = 1'b0;
    case (state)
      IDLE: begin
        if (Load_Start) state_nxt = LEN;
      end
      LEN: begin
        Rx_Ready  = 1'b1;
        Core_Hold = 1'b1;
        if (word_valid) begin
          if (word == '0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = DONE;
`endif
          end else if (word > 32'(MEM_SIZE)) begin
            state_nxt = ERROR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        Rx_Ready  = 1'b1;
        Core_Hold = 1'b1;
        if (word_valid) state_nxt = WRITE;
      end
      WRITE: begin
        Imem_We   = 1'b1;
        Core_Hold = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      CHECK: begin
        Rx_Ready  = 1'b1;
        Core_Hold = 1'b1;
        if (word_valid) state_nxt = (word == sum_q) ? DONE : ERROR;
      end
`endif
      DONE: begin
        Load_Done = 1'b1;
        if (Load_Start) state_nxt = LEN;
      end
      ERROR: begin
        Load_Error = 1'b1;
        if (Load_Start) state_nxt = LEN;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams against a
// queue-based model of expected memory writes and completion status.
module tb_imem_loader;

  localparam int unsigned TB_MEM  = 64;
  localparam logic [31:0] TB_BASE = 32'h0000_0100;

  logic        Clk_Core   = 1'b0;
  logic        Rst_Core   = 1'b1;
  logic        Load_Start = 1'b0;
  logic [7:0]  Rx_Data    = '0;
  logic        Rx_Valid   = 1'b0;
  logic        Rx_Ready;
  logic        Imem_We;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Wdata;
  logic        Core_Hold;
  logic        Load_Done;
  logic        Load_Error;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] stim_words[0:127];

  imem_loader #(.MEM_SIZE(TB_MEM), .BASE_ADDR(TB_BASE)) dut (
    .Clk_Core   (Clk_Core),
    .Rst_Core   (Rst_Core),
    .Load_Start (Load_Start),
    .Rx_Data    (Rx_Data),
    .Rx_Valid   (Rx_Valid),
    .Rx_Ready   (Rx_Ready),
    .Imem_We    (Imem_We),
    .Imem_Addr  (Imem_Addr),
    .Imem_Wdata (Imem_Wdata),
    .Core_Hold  (Core_Hold),
    .Load_Done  (Load_Done),
    .Load_Error (Load_Error)
  );

  always #5 Clk_Core = ~Clk_Core;

  always @(negedge Clk_Core) begin
    if (Imem_We === 1'b1) begin
      obs_addr.push_back(Imem_Addr);
      obs_data.push_back(Imem_Wdata);
    end
  end

  task automatic tick();
    @(posedge Clk_Core);
    #1;
  endtask

  task automatic pulse_start();
    Load_Start = 1'b1;
    tick();
    Load_Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned gap;
    bit ok;
    gap = $urandom_range(0, 2);
    ok  = 1'b0;
    for (int i = 0; i < int'(gap); i++) tick();
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge Clk_Core);
      if (Rx_Ready === 1'b1) ok = 1'b1;
      tick();
    end
    Rx_Valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: Rx_Ready stayed %b, required 1", Rx_Ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  // Model: N words land at BASE + 4*i in order; status is error when N exceeds
  // the memory depth or (checksum build) the sent sum differs from the true sum.
  task automatic run_session(input int unsigned n, input bit bad_sum, input bit poke_start,
                             input string tag);
    logic [31:0] nv;
    logic [31:0] sum;
    bit          expect_err;
    int unsigned n_wr;
    nv  = n;
    sum = '0;
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    send_word(nv);
    if (n > TB_MEM) begin
      n_cmp++;
      if (Load_Error !== 1'b1 || Rx_Ready !== 1'b0 || Core_Hold !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_oversize_immediate: err/ready/hold=%b%b%b, required 100",
                 tag, Load_Error, Rx_Ready, Core_Hold);
      end
      expect_err = 1'b1;
      n_wr       = 0;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        for (int b = 0; b < 4; b++) begin
          send_byte(stim_words[i][8*b +: 8]);
          if (poke_start && i == 0 && b == 1) pulse_start();
        end
        sum = sum + stim_words[i];
      end
      expect_err = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      send_word(bad_sum ? sum + 32'd1 : sum);
      expect_err = bad_sum;
`endif
      n_wr = n;
    end
    for (int i = 0; i < 20 && !(Load_Done === 1'b1 || Load_Error === 1'b1); i++) tick();

    n_cmp++;
    if (obs_addr.size() != n_wr) begin
      n_bad++;
      $display("FAIL %s_write_count: got %0d, required %0d", tag, obs_addr.size(), n_wr);
    end
    for (int i = 0; i < obs_addr.size() && i < int'(n_wr); i++) begin
      n_cmp++;
      if (obs_addr[i] !== TB_BASE + 32'(4 * i) || obs_data[i] !== stim_words[i]) begin
        n_bad++;
        $display("FAIL %s_write%0d: got addr=%h data=%h, required addr=%h data=%h", tag, i,
                 obs_addr[i], obs_data[i], TB_BASE + 32'(4 * i), stim_words[i]);
      end
    end
    n_cmp++;
    if (Load_Done !== !expect_err || Load_Error !== expect_err) begin
      n_bad++;
      $display("FAIL %s_status: done/err=%b%b, required %b%b", tag, Load_Done, Load_Error,
               !expect_err, expect_err);
    end
    n_cmp++;
    if (Core_Hold !== 1'b0 || Rx_Ready !== 1'b0 || Imem_We !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_final_idle: hold/ready/we=%b%b%b, required 000", tag, Core_Hold,
               Rx_Ready, Imem_We);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({Rx_Ready, Imem_We, Core_Hold, Load_Done, Load_Error} !== 5'b0 ||
        Imem_Addr !== 32'h0 || Imem_Wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: flags=%b addr=%h wdata=%h, required all zero",
               {Rx_Ready, Imem_We, Core_Hold, Load_Done, Load_Error}, Imem_Addr, Imem_Wdata);
    end
  endtask

  task automatic test_basic();
    stim_words[0] = 32'h0000_0013;
    stim_words[1] = 32'h0010_0093;
    stim_words[2] = 32'hDEAD_BEEF;
    run_session(3, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_zero();
    run_session(0, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_oversize();
    run_session(TB_MEM + 1, 1'b0, 1'b0, "oversize");
  endtask

  task automatic test_mid_reset();
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    Rst_Core = 1'b1;
    tick();
    Rst_Core = 1'b0;
    n_cmp++;
    if ({Rx_Ready, Imem_We, Core_Hold, Load_Done, Load_Error} !== 5'b0 ||
        Imem_Addr !== 32'h0 || Imem_Wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs: flags=%b addr=%h wdata=%h, required all zero",
               {Rx_Ready, Imem_We, Core_Hold, Load_Done, Load_Error}, Imem_Addr, Imem_Wdata);
    end
    n_cmp++;
    if (obs_addr.size() != 0) begin
      n_bad++;
      $display("FAIL midreset_no_write: got %0d writes, required 0", obs_addr.size());
    end
    stim_words[0] = 32'hCAFE_F00D;
    run_session(1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_start_ignored();
    stim_words[0] = $urandom;
    stim_words[1] = $urandom;
    run_session(2, 1'b0, 1'b1, "start_in_data");
    pulse_start();
    n_cmp++;
    if (Load_Done !== 1'b0 || Load_Error !== 1'b0 || Core_Hold !== 1'b1 || Rx_Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_from_done: done/err/hold/ready=%b%b%b%b, required 0011",
               Load_Done, Load_Error, Core_Hold, Rx_Ready);
    end
    stim_words[0] = $urandom;
    run_session(1, 1'b0, 1'b0, "restarted");
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      int unsigned n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < int'(n); i++) stim_words[i] = $urandom;
      run_session(n, 1'b0, 1'b0, "random");
    end
    for (int i = 0; i < int'(TB_MEM); i++) stim_words[i] = $urandom;
    run_session(TB_MEM, 1'b0, 1'b0, "full_depth");
  endtask

`ifdef IMEM_LOADER_CHKSUM_EN
  task automatic test_checksum();
    stim_words[0] = 32'h1;
    stim_words[1] = 32'h2;
    run_session(2, 1'b0, 1'b0, "chksum_good");
    run_session(2, 1'b1, 1'b0, "chksum_bad");
  endtask
`endif

  initial begin
    Rst_Core = 1'b1;
    repeat (3) tick();
    test_reset();
    Rst_Core = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_zero();
    test_oversize();
    test_mid_reset();
    test_start_ignored();
    test_random();
`ifdef IMEM_LOADER_CHKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
